genfifo_dc: RTL

Parametrised dual-clock FIFO with Gray-coded pointer crossing, full/empty and programmable almost-full/almost-empty flags, and overflow/underflow pulses. It holds its own storage and sits between a write-clock producer and a read-clock consumer as the general clock-domain-crossing buffer for the design.

---
 rtl/genfifo_pkg.sv | 30 +++
 rtl/genfifo_sync.sv | 25 ++
 rtl/genfifo_dc.sv | 120 ++++++++++++
 3 files changed

// File: rtl/genfifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray conversion and depth/pointer sizing.
package genfifo_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra pointer bit distinguishes full from empty when addresses match.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/genfifo_sync.sv
// Multi-flop synchroniser for Gray-coded pointers; async active-high reset.
module genfifo_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/genfifo_dc.sv
// Dual-clock FIFO with Gray pointer crossing and full/empty/almost/error flags.
// Define GENFIFO_LEVEL_EN to export the wlevel/rlevel fill-level ports.
module genfifo_dc
  import genfifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2,
  parameter int AE_MARGIN   = 2
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              rclk,
  input  logic              rrst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              almost_full,
  output logic              wovf,
  input  logic              re,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              almost_empty,
  output logic              rudf
`ifdef GENFIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   wlevel,
  output logic [ADDR_W:0]   rlevel
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int PTR_W = ptr_width(ADDR_W);
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);
  localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AE_MARGIN);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr, wptr_next, wgray, wgray_next, rgray_sync, wlevel_next;
  logic [PTR_W-1:0] rptr, rptr_next, rgray, rgray_next, wgray_sync, rlevel_next;
  logic             wr_en, rd_en;

  genfifo_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (rgray),
    .q   (rgray_sync)
  );

  genfifo_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk (rclk),
    .rst (rrst),
    .d   (wgray),
    .q   (wgray_sync)
  );

  // Write domain: flags come from the post-increment pointer so they never lag a local write.
  assign wr_en       = we && !full;
  assign wptr_next   = wptr + PTR_W'(wr_en);
  assign wgray_next  = PTR_W'(bin2gray(gray_word_t'(wptr_next)));
  assign wlevel_next = wptr_next - PTR_W'(gray2bin(gray_word_t'(rgray_sync)));

  always_ff @(posedge wclk) begin
    if (wr_en) mem[wptr[ADDR_W-1:0]] <= wdata;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wptr        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wovf        <= 1'b0;
    end else begin
      wptr        <= wptr_next;
      wgray       <= wgray_next;
      full        <= (wgray_next == {~rgray_sync[ADDR_W:ADDR_W-1], rgray_sync[ADDR_W-2:0]});
      almost_full <= (wlevel_next >= AF_LEVEL);
      wovf        <= we && full;
    end
  end

  // Read domain mirrors the write side.
  assign rd_en       = re && !empty;
  assign rptr_next   = rptr + PTR_W'(rd_en);
  assign rgray_next  = PTR_W'(bin2gray(gray_word_t'(rptr_next)));
  assign rlevel_next = PTR_W'(gray2bin(gray_word_t'(wgray_sync))) - rptr_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rptr         <= '0;
      rgray        <= '0;
      rdata        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rudf         <= 1'b0;
    end else begin
      rptr         <= rptr_next;
      rgray        <= rgray_next;
      if (rd_en) rdata <= mem[rptr[ADDR_W-1:0]];
      empty        <= (rgray_next == wgray_sync);
      almost_empty <= (rlevel_next <= AE_LEVEL);
      rudf         <= re && empty;
    end
  end

`ifdef GENFIFO_LEVEL_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) wlevel <= '0;
    else      wlevel <= wlevel_next;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) rlevel <= '0;
    else      rlevel <= rlevel_next;
  end
`endif

endmodule
